// File: rtl/hilo_unit.sv
// hilo_unit: architectural HI/LO registers for the execute stage.
// MTHI/MTLO write in a single cycle. MULT/MULTU/DIV/DIVU run one bit per
// cycle over XLEN cycles. Shift-add is used for multiply and restoring
// division for divide. Signs are fixed up on completion.
//
// Ports:
//   clk, rst_b          clock (rising edge), asynchronous active-low reset
//   op_valid, op_code   HI/LO-writing op from execute
//                       (0 MTHI, 1 MTLO, 2 MULTU, 3 MULT, 4 DIVU, 5 DIV)
//   l_value, r_value    rs / rt operands, sampled only on acceptance
//   op_ready            high when a new op can be accepted (!busy)
//   rd_hi_req/rd_lo_req MFHI / MFLO in execute (HI wins if both are set)
//   rd_data             combinational read data (0 when there is no request)
//   stall               combinational pipeline stall while busy
//   busy                iterative op in flight
//   hi, lo              architectural HI / LO
//   div_by_zero         one-cycle pulse when a divide by zero completes
module hilo_unit #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_b,
   input  logic            op_valid,
   input  logic [2:0]      op_code,
   input  logic [XLEN-1:0] l_value,
   input  logic [XLEN-1:0] r_value,
   output logic            op_ready,
   input  logic            rd_hi_req,
   input  logic            rd_lo_req,
   output logic [XLEN-1:0] rd_data,
   output logic            stall,
   output logic            busy,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            div_by_zero
);

   localparam int unsigned DW = 2 * XLEN;
   localparam int unsigned CW = $clog2(XLEN);
   localparam logic [CW-1:0] CNT_START = CW'(XLEN - 1);

   localparam logic [2:0] OP_MTHI  = 3'd0;
   localparam logic [2:0] OP_MTLO  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_MULT  = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_DIV   = 3'd5;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            finish_c;

   // Iteration state. acc_q holds {partial, multiplier} for a multiply and
   // {remainder, dividend/quotient} for a divide.
   logic [DW-1:0]   acc_q;
   logic [XLEN-1:0] opnd_q;
   logic [XLEN-1:0] l_raw_q;
   logic            is_div_q;
   logic            neg_res_q;
   logic            neg_rem_q;
   logic            dz_q;

   // Decode of the op presented this cycle.
   logic            accept_c, start_c, is_signed_c, is_div_c;
   logic            l_neg_c, r_neg_c;
   logic [XLEN-1:0] l_mag_c, r_mag_c;

   // One iteration step.
   logic [XLEN:0]   mul_sum_c;
   logic [DW-1:0]   mul_next_c;
   logic [XLEN:0]   div_shift_c;
   logic            div_ge_c;
   logic [XLEN-1:0] div_rem_c;
   logic [DW-1:0]   div_next_c;

   // Final result, formed during the last iteration.
   logic [DW-1:0]   prod_c;
   logic [XLEN-1:0] quo_c, rem_c;
   logic [XLEN-1:0] res_hi_c, res_lo_c;

   assign busy     = (state_q == S_RUN);
   assign op_ready = ~busy;
   assign stall    = busy & (op_valid | rd_hi_req | rd_lo_req);
   assign rd_data  = rd_hi_req ? hi : (rd_lo_req ? lo : '0);

   // Op decode and operand magnitudes.
   always_comb begin
      accept_c    = op_valid & op_ready & (op_code <= OP_DIV);
      start_c     = accept_c & (op_code >= OP_MULTU);
      is_signed_c = (op_code == OP_MULT) | (op_code == OP_DIV);
      is_div_c    = (op_code == OP_DIVU) | (op_code == OP_DIV);
      l_neg_c     = is_signed_c & l_value[XLEN-1];
      r_neg_c     = is_signed_c & r_value[XLEN-1];
      l_mag_c     = l_neg_c ? (~l_value + XLEN'(1)) : l_value;
      r_mag_c     = r_neg_c ? (~r_value + XLEN'(1)) : r_value;
   end

   // One shift-add multiply step and one restoring divide step.
   always_comb begin
      mul_sum_c   = {1'b0, acc_q[DW-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next_c  = {mul_sum_c, acc_q[XLEN-1:1]};
      div_shift_c = {acc_q[DW-1:XLEN], acc_q[XLEN-1]};
      div_ge_c    = (div_shift_c >= {1'b0, opnd_q});
      // When the subtraction succeeds, the difference is smaller than the
      // divisor, so it fits in XLEN bits.
      div_rem_c   = div_ge_c ? (div_shift_c[XLEN-1:0] - opnd_q) : div_shift_c[XLEN-1:0];
      div_next_c  = {div_rem_c, acc_q[XLEN-2:0], div_ge_c};
   end

   // Sign fix-up and the divide-by-zero override.
   always_comb begin
      prod_c   = neg_res_q ? (~mul_next_c + DW'(1)) : mul_next_c;
      quo_c    = div_next_c[XLEN-1:0];
      rem_c    = div_next_c[DW-1:XLEN];
      res_hi_c = prod_c[DW-1:XLEN];
      res_lo_c = prod_c[XLEN-1:0];
      if (is_div_q) begin
         if (dz_q) begin
            res_hi_c = l_raw_q;
            res_lo_c = '1;
         end else begin
            res_hi_c = neg_rem_q ? (~rem_c + XLEN'(1)) : rem_c;
            res_lo_c = neg_res_q ? (~quo_c + XLEN'(1)) : quo_c;
         end
      end
   end

   // FSM state and iteration counter registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      finish_c = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_c) begin
               state_d = S_RUN;
               cnt_d   = CNT_START;
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               state_d  = S_IDLE;
               finish_c = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      endcase
   end

   // HI/LO and datapath registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         hi          <= '0;
         lo          <= '0;
         acc_q       <= '0;
         opnd_q      <= '0;
         l_raw_q     <= '0;
         is_div_q    <= 1'b0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         dz_q        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         div_by_zero <= finish_c & is_div_q & dz_q;
         if (accept_c) begin
            case (op_code)
               OP_MTHI: hi <= l_value;
               OP_MTLO: lo <= l_value;
               default: begin
                  acc_q     <= {{XLEN{1'b0}}, (is_div_c ? l_mag_c : r_mag_c)};
                  opnd_q    <= is_div_c ? r_mag_c : l_mag_c;
                  l_raw_q   <= l_value;
                  is_div_q  <= is_div_c;
                  neg_res_q <= l_neg_c ^ r_neg_c;
                  neg_rem_q <= l_neg_c;
                  dz_q      <= (r_value == '0);
               end
            endcase
         end else if (busy) begin
            acc_q <= is_div_q ? div_next_c : mul_next_c;
            if (finish_c) begin
               hi <= res_hi_c;
               lo <= res_lo_c;
            end
         end
      end
   end

endmodule

// File: doc/hilo_unit.md
# hilo_unit

Multi-cycle HI/LO unit for the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations, computes products and quotient/remainder iteratively over 32 cycles, and holds the architectural HI and LO registers. Serves MFHI/MFLO reads and stalls the pipeline while a multiply or divide is in flight.

## Interface
- XLEN, 32, operand and HI/LO width; only 32 is supported.

- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- op_valid  in  1  execute stage presents a HI/LO-writing op
- op_code  in  3  0 MTHI, 1 MTLO, 2 MULTU, 3 MULT, 4 DIVU, 5 DIV; 6 and 7 are ignored (never accepted, no state change)
- l_value  in  XLEN  rs operand (dividend / multiplicand / MTHI-MTLO source)
- r_value  in  XLEN  rt operand (divisor / multiplier)
- op_ready  out  1  equals !busy
- rd_hi_req  in  1  MFHI in execute
- rd_lo_req  in  1  MFLO in execute
- rd_data  out  XLEN  combinational: HI if rd_hi_req, else LO if rd_lo_req, else 0
- stall  out  1  combinational: busy & (op_valid | rd_hi_req | rd_lo_req)
- busy  out  1  iterative op in progress
- hi  out  XLEN  registered HI
- lo  out  XLEN  registered LO
- div_by_zero  out  1  one-cycle pulse on completion of DIV/DIVU with r_value == 0

## Operation
- Accept = op_valid & op_ready & (op_code <= 5).
- MTHI/MTLO: write l_value into HI/LO at the accepting edge; no busy.
- MULT/MULTU/DIV/DIVU: latch operand magnitudes, sign flags and op type at the accepting edge.
  - Signed ops take absolute values; unsigned ops use operands as-is.
  - Enter RUN with counter = 31.
- FSM states:
  - IDLE -> RUN on accepted mult/div.
  - RUN decrements the counter each cycle.
  - RUN with counter == 0 writes HI/LO and goes to IDLE.
- Multiply: shift-add, one multiplier bit per cycle into a 64-bit accumulator.
  - Final product is negated (64-bit two's complement) if MULT and the operand signs differ.
  - HI = product[63:32], LO = product[31:0].
- Divide: restoring, one quotient bit per cycle.
  - Quotient is negated if DIV and the signs differ.
  - Remainder takes the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (either flavour): LO = 0xFFFFFFFF, HI = l_value as latched (original signed value); div_by_zero pulses in the completion cycle.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0 (wraps, no flag).
- Reads never modify state. When both rd_hi_req and rd_lo_req are set, HI wins.
- No bypass: a read in the same cycle as an accepted MTHI/MTLO returns the old value.

## Timing
- Reset (asynchronous, any state including mid-RUN): HI = 0, LO = 0, FSM = IDLE, counter = 0, busy = 0, div_by_zero = 0. op_ready = 1 and stall = 0 immediately on reset assertion.
- Latency:
  - Mult/div accepted at edge E0.
  - busy is high for exactly 32 cycles, E0 through E32.
  - HI/LO update at E32; busy falls at E32.
  - The first read after busy falls returns the new values.
- MTHI/MTLO: written at the accepting edge; visible the next cycle.
- While busy:
  - Ops are not accepted; the requester holds op_valid/op_code/operands and sees stall = 1.
  - Reads see stall = 1; rd_data still reflects the current (old) HI/LO and must be ignored by the pipeline.
- In the cycle busy is low, an op may be accepted and a read served simultaneously; the read gets the pre-op values.
- Operands are sampled only at acceptance; later changes have no effect.

## Test plan
- Reset, then DIVU l=100 r=7 -> busy high 32 cycles, then LO = 14, HI = 2, div_by_zero stays 0.
- DIV l=0xFFFFFFF9 (-7) r=2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- Products of 0xFFFFFFFF × 2:
  - MULT -> HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
  - MULTU -> HI = 0x00000001, LO = 0xFFFFFFFE.
- DIVU l=0x1234 r=0 -> LO = 0xFFFFFFFF, HI = 0x1234, div_by_zero high exactly 1 cycle at completion.
- MULTU 3×5, then rd_lo_req held from the next cycle -> stall = 1 for 32 cycles, then rd_data = 15 with stall = 0. MTHI 0xA5A5A5A5 issued during busy is held, then accepted in the cycle busy falls; HI reads 0xA5A5A5A5 the following cycle.
- DIVU started, rst_b pulsed low at RUN cycle 10 -> HI = LO = 0, busy = 0 asynchronously; no completion or div_by_zero pulse follows.
